// File: rtl/stopwatch_bcd_core.sv
// Stopwatch core: counts base-tick toggles as centiseconds in MM:SS.cc BCD
// and owns the run/pause/lap/clear control plus the timer enable.
module stopwatch_bcd_core #(
  parameter int unsigned MAX_MIN = 99
) (
  input  logic       i_sclk,
  input  logic       i_reset_n,
  input  logic       i_base_tick,
  input  logic       i_start_stop,
  input  logic       i_lap,
  input  logic       i_clear,
  output logic       o_timerenb,
  output logic [7:0] o_cs_bcd,
  output logic [7:0] o_sec_bcd,
  output logic [7:0] o_min_bcd,
  output logic       o_running,
  output logic       o_lap_hold,
  output logic       o_overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_U = 4'(MAX_MIN % 10);

  // digit order, low to high: cs units, cs tens, sec units,
  // sec tens, min units, min tens
  localparam logic [5:0][3:0] LIM = {
    4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9
  };
  localparam logic [5:0][3:0] TOP = {
    MAX_T, MAX_U, 4'd5, 4'd9, 4'd9, 4'd9
  };

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic             tick_q;
  logic             overflow;
  logic [5:0][3:0]  live;
  logic [5:0][3:0]  frozen;
  logic [5:0][3:0]  live_inc;
  logic [5:0][3:0]  shown;

  logic evt;
  logic active;
  logic inc;
  logic at_max;
  logic snap;
  logic carry;

  assign evt    = i_base_tick ^ tick_q;
  assign active = (state == S_RUN) || (state == S_LAP);
  assign inc    = evt && active;
  assign at_max = (live == TOP);

  always_comb begin
    live_inc = live;
    carry    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (live[i] == LIM[i]) begin
          live_inc[i] = 4'd0;
        end else begin
          live_inc[i] = live[i] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    snap    = 1'b0;
    if (i_start_stop) begin
      unique case (state)
        S_IDLE:  state_n = S_RUN;
        S_RUN:   state_n = S_PAUSE;
        S_LAP:   state_n = S_PAUSE;
        S_PAUSE: state_n = overflow ? S_PAUSE : S_RUN;
        default: state_n = S_IDLE;
      endcase
    end else if (i_lap && active) begin
      state_n = S_LAP;
      snap    = 1'b1;
    end
    // saturation always parks the watch, whatever the pulses asked for
    if (inc && at_max) begin
      state_n = S_PAUSE;
    end
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      tick_q   <= 1'b0;
      overflow <= 1'b0;
      live     <= '0;
      frozen   <= '0;
    end else begin
      tick_q <= i_base_tick;
      if (i_clear) begin
        state    <= S_IDLE;
        overflow <= 1'b0;
        live     <= '0;
        frozen   <= '0;
      end else begin
        state <= state_n;
        if (snap) begin
          frozen <= live;
        end
        if (inc) begin
          if (at_max) begin
            overflow <= 1'b1;
          end else begin
            live <= live_inc;
          end
        end
      end
    end
  end

  always_comb begin
    shown = live;
    unique case (1'b1)
      (state == S_LAP): shown = frozen;
      default:          shown = live;
    endcase
  end

  assign o_timerenb = active;
  assign o_running  = active;
  assign o_lap_hold = (state == S_LAP);
  assign o_overflow = overflow;
  assign o_cs_bcd   = {shown[1], shown[0]};
  assign o_sec_bcd  = {shown[3], shown[2]};
  assign o_min_bcd  = {shown[5], shown[4]};

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Bench for stopwatch_bcd_core: centisecond-count reference model feeding
// a scoreboard queue, plus directed boundary checks.
module tb_stopwatch_bcd_core;

  localparam int unsigned MAX_MIN = 1;
  localparam int MAX_CNT = MAX_MIN * 6000 + 5999;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic       clk;
  logic       rst_n;
  logic       base_tick;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic       timerenb;
  logic [7:0] cs_bcd;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic       running;
  logic       lap_hold;
  logic       overflow;

  typedef struct {
    logic [23:0] disp;
    logic        run;
    logic        hold;
    logic        ovf;
  } exp_t;

  exp_t q[$];

  int tests;
  int fails;

  int cnt;
  int frz;
  int st;
  bit ovf;
  bit tick;

  stopwatch_bcd_core #(.MAX_MIN(MAX_MIN)) dut (
    .i_sclk      (clk),
    .i_reset_n   (rst_n),
    .i_base_tick (base_tick),
    .i_start_stop(start_stop),
    .i_lap       (lap),
    .i_clear     (clear),
    .o_timerenb  (timerenb),
    .o_cs_bcd    (cs_bcd),
    .o_sec_bcd   (sec_bcd),
    .o_min_bcd   (min_bcd),
    .o_running   (running),
    .o_lap_hold  (lap_hold),
    .o_overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] disp_of(input int v);
    int m;
    int s;
    int c;
    m = v / 6000;
    s = (v / 100) % 60;
    c = v % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10),
            4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.disp = disp_of(st == M_LAP ? frz : cnt);
    e.run  = (st == M_RUN) || (st == M_LAP);
    e.hold = (st == M_LAP);
    e.ovf  = ovf;
    return e;
  endfunction

  task automatic model(input bit evt, input bit ss,
                       input bit lp, input bit cl);
    bit act;
    int nst;
    if (cl) begin
      st  = M_IDLE;
      cnt = 0;
      frz = 0;
      ovf = 0;
    end else begin
      act = (st == M_RUN) || (st == M_LAP);
      nst = st;
      if (ss) begin
        if (st == M_IDLE) nst = M_RUN;
        else if (st == M_RUN || st == M_LAP) nst = M_PAUSE;
        else if (!ovf) nst = M_RUN;
      end else if (lp && act) begin
        nst = M_LAP;
        frz = cnt;
      end
      if (evt && act) begin
        if (cnt == MAX_CNT) begin
          ovf = 1;
          nst = M_PAUSE;
        end else begin
          cnt = cnt + 1;
        end
      end
      st = nst;
    end
  endtask

  task automatic step(input bit tg, input bit ss,
                      input bit lp, input bit cl);
    @(negedge clk);
    if (tg) tick = ~tick;
    base_tick  = tick;
    start_stop = ss;
    lap        = lp;
    clear      = cl;
    model(tg, ss, lp, cl);
    q.push_back(expect_now());
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [23:0] d,
                     input bit r, input bit h, input bit o);
    tests++;
    if ({min_bcd, sec_bcd, cs_bcd} !== d || running !== r ||
        timerenb !== r || lap_hold !== h || overflow !== o) begin
      fails++;
      $display("FAIL %s: got %h run%b en%b hold%b ovf%b, want %h run%b hold%b ovf%b",
               name, {min_bcd, sec_bcd, cs_bcd}, running, timerenb,
               lap_hold, overflow, d, r, h, o);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        tests++;
        if ({min_bcd, sec_bcd, cs_bcd} !== e.disp || running !== e.run ||
            timerenb !== e.run || lap_hold !== e.hold ||
            overflow !== e.ovf) begin
          fails++;
          $display("FAIL sb t=%0t: got %h run%b en%b hold%b ovf%b, want %h run%b hold%b ovf%b",
                   $time, {min_bcd, sec_bcd, cs_bcd}, running, timerenb,
                   lap_hold, overflow, e.disp, e.run, e.hold, e.ovf);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    cnt = 0;
    frz = 0;
    st = M_IDLE;
    ovf = 0;
    tick = 0;
    rst_n = 1'b0;
    base_tick = 1'b0;
    start_stop = 1'b0;
    lap = 1'b0;
    clear = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_init", 24'h000000, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset asserted mid-run
    step(0, 1, 0, 0);
    ticks(42);
    drain();
    chk("pre_reset_042", 24'h000042, 1, 0, 0);
    #1;
    rst_n = 1'b0;
    tick = 0;
    base_tick = 1'b0;
    #1;
    chk("async_reset", 24'h000000, 0, 0, 0);
    cnt = 0;
    frz = 0;
    st = M_IDLE;
    ovf = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // run, pause, resume
    step(0, 1, 0, 0);
    ticks(100);
    drain();
    chk("run_100", 24'h000100, 1, 0, 0);
    step(0, 1, 0, 0);
    ticks(10);
    drain();
    chk("paused", 24'h000100, 0, 0, 0);
    step(0, 1, 0, 0);
    ticks(1);
    drain();
    chk("resume_1", 24'h000101, 1, 0, 0);

    // minute carry
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(5999);
    drain();
    chk("cnt_5999", 24'h005999, 1, 0, 0);
    ticks(1);
    drain();
    chk("cnt_6000", 24'h010000, 1, 0, 0);

    // lap freeze and re-snapshot
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(250);
    step(0, 0, 1, 0);
    drain();
    chk("lap_250", 24'h000250, 1, 1, 0);
    ticks(100);
    drain();
    chk("lap_frozen", 24'h000250, 1, 1, 0);
    step(0, 0, 1, 0);
    drain();
    chk("lap_again", 24'h000350, 1, 1, 0);
    step(0, 1, 0, 0);
    drain();
    chk("lap_pause", 24'h000350, 0, 0, 0);

    // saturation
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(11999);
    drain();
    chk("sat_edge", 24'h015999, 1, 0, 0);
    ticks(1);
    drain();
    chk("sat_hit", 24'h015999, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(5);
    drain();
    chk("sat_ss_ignored", 24'h015999, 0, 0, 1);
    step(0, 0, 0, 1);
    drain();
    chk("sat_clear", 24'h000000, 0, 0, 0);

    // clear beats start_stop
    step(0, 1, 0, 0);
    ticks(37);
    step(1, 1, 0, 1);
    drain();
    chk("clear_wins", 24'h000000, 0, 0, 0);

    // randomized pulses and ticks
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 399) == 0));
    end
    drain();

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
